apb_pwm_slave: RTL and testbench



---
 rtl/pwm_pkg.sv | 28 ++
 rtl/pwm_core.sv | 44 ++++
 rtl/apb_pwm_slave.sv | 136 +++++++++++++
 tb/tb_apb_pwm_slave.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - register offsets, bit indices and APB FSM states for the PWM slave
package pwm_pkg;

    localparam logic [4:0] PWM_CTRL   = 5'h00;
    localparam logic [4:0] PWM_PERIOD = 5'h04;
    localparam logic [4:0] PWM_DUTY   = 5'h08;
    localparam logic [4:0] PWM_STATUS = 5'h0C;
    localparam logic [4:0] PWM_CNT    = 5'h10;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_POL  = 1;
    localparam int CTRL_IE   = 2;
    localparam int STAT_WRAP = 0;
    localparam int STAT_RUN  = 1;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_ACCESS = 2'd1,
        APB_DONE   = 2'd2
    } apb_state_t;

    // Anything outside the five word registers, misaligned, or a write to the read-only counter.
    function automatic logic decode_err(input logic [31:0] addr, input logic write);
        return (|addr[31:5]) || (|addr[1:0]) || (addr[4:0] > PWM_CNT) ||
               (write && (addr[4:0] == PWM_CNT));
    endfunction

endpackage

// File: rtl/pwm_core.sv
// rtl/pwm_core.sv - counter/compare PWM engine with period-boundary reload of period and duty
module pwm_core #(
    parameter int CNT_W = 16
) (
    input  logic             pclk,
    input  logic             presetn,
    input  logic             en,
    input  logic             pol,
    input  logic [CNT_W-1:0] per_s,
    input  logic [CNT_W-1:0] duty_s,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output logic             pwm_out,
    output logic             run
);

    logic [CNT_W-1:0] per_a;
    logic [CNT_W-1:0] duty_a;
    logic             raw;

    assign wrap = en && (cnt == per_a);
    assign run  = en;
    assign raw  = (cnt < duty_a);

    // Actives follow the shadows while stopped so the first enabled period uses fresh values.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt     <= '0;
            per_a   <= '0;
            duty_a  <= '0;
            pwm_out <= 1'b0;
        end else begin
            if (!en || wrap) begin
                per_a  <= per_s;
                duty_a <= duty_s;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            pwm_out <= en ? (raw ^ pol) : pol;
        end
    end

endmodule

// File: rtl/apb_pwm_slave.sv
// rtl/apb_pwm_slave.sv - APB completer with PWM register bank, error decode and wait-state FSM
module apb_pwm_slave
    import pwm_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic [31:0] paddr,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        pwm_out,
    output logic        irq
);

    localparam logic [1:0] WS_CNT = 2'(WAIT_STATES);

    apb_state_t       state;
    logic [1:0]       wcnt;
    logic             setup_req;
    logic             access_act;
    logic             xfer_err;
    logic             wr_commit;
    logic [4:0]       ofs;
    logic [2:0]       ctrl;
    logic [CNT_W-1:0] per_s;
    logic [CNT_W-1:0] duty_s;
    logic             wrap_flag;
    logic [CNT_W-1:0] cnt;
    logic             core_wrap;
    logic             run;
    logic [31:0]      rdata;
    logic             unused_pwdata;

    assign unused_pwdata = ^pwdata;

    assign setup_req  = psel && !penable;
    assign access_act = psel && penable;
    assign ofs        = paddr[4:0];
    assign xfer_err   = decode_err(paddr, pwrite);
    assign pready     = (state == APB_ACCESS) && access_act && (wcnt == WS_CNT);
    assign wr_commit  = pready && pwrite && !xfer_err;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= APB_IDLE;
            wcnt  <= '0;
        end else begin
            case (state)
                APB_IDLE, APB_DONE: begin
                    wcnt  <= '0;
                    state <= setup_req ? APB_ACCESS : APB_IDLE;
                end
                APB_ACCESS: begin
                    if (!psel) begin
                        state <= APB_IDLE;
                        wcnt  <= '0;
                    end else if (pready) begin
                        state <= APB_DONE;
                    end else if (access_act) begin
                        wcnt <= wcnt + 2'd1;
                    end
                end
                default: begin
                    state <= APB_IDLE;
                    wcnt  <= '0;
                end
            endcase
        end
    end

    // A hardware wrap outranks a same-cycle write-1-to-clear so no wrap event is lost.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            ctrl      <= '0;
            per_s     <= '0;
            duty_s    <= '0;
            wrap_flag <= 1'b0;
        end else begin
            if (wr_commit) begin
                case (ofs)
                    PWM_CTRL:   ctrl   <= pwdata[2:0];
                    PWM_PERIOD: per_s  <= pwdata[CNT_W-1:0];
                    PWM_DUTY:   duty_s <= pwdata[CNT_W-1:0];
                    default:    ;
                endcase
            end
            if (core_wrap) begin
                wrap_flag <= 1'b1;
            end else if (wr_commit && (ofs == PWM_STATUS) && pwdata[STAT_WRAP]) begin
                wrap_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (ofs)
            PWM_CTRL:   rdata = 32'(ctrl);
            PWM_PERIOD: rdata = 32'(per_s);
            PWM_DUTY:   rdata = 32'(duty_s);
            PWM_STATUS: begin
                rdata[STAT_WRAP] = wrap_flag;
                rdata[STAT_RUN]  = run;
            end
            PWM_CNT:    rdata = 32'(cnt);
            default:    rdata = '0;
        endcase
    end

    assign prdata  = (pready && !pwrite && !xfer_err) ? rdata : '0;
    assign pslverr = pready && xfer_err;
    assign irq     = wrap_flag && ctrl[CTRL_IE];

    pwm_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .pclk    (pclk),
        .presetn (presetn),
        .en      (ctrl[CTRL_EN]),
        .pol     (ctrl[CTRL_POL]),
        .per_s   (per_s),
        .duty_s  (duty_s),
        .cnt     (cnt),
        .wrap    (core_wrap),
        .pwm_out (pwm_out),
        .run     (run)
    );

endmodule

// File: tb/tb_apb_pwm_slave.sv
// tb/tb_apb_pwm_slave.sv - directed and randomized APB traffic against a time-based PWM model
module tb_apb_pwm_slave;

    localparam int CNT_W = 16;
    localparam int WS    = 1;

    logic        pclk    = 1'b0;
    logic        presetn = 1'b0;
    logic [31:0] paddr   = '0;
    logic        psel    = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite  = 1'b0;
    logic [31:0] pwdata  = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        pwm_out;
    logic        irq;

    apb_pwm_slave #(.CNT_W(CNT_W), .WAIT_STATES(WS)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .paddr   (paddr),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .pwm_out (pwm_out),
        .irq     (irq)
    );

    always #5 pclk = ~pclk;

    int   vectors     = 0;
    int   miscompares = 0;
    logic exp_ready   = 1'b0;

    // Model: register contents plus the start cycle of the current PWM period.
    logic        m_en = 0, m_pol = 0, m_ie = 0, m_wrap = 0, m_pwm = 0;
    int unsigned m_per = 0, m_duty = 0, m_per_a = 0, m_duty_a = 0;
    int unsigned cyc = 0, m_start = 0;
    logic        rdy_t, err_t, wr_ok, hit;
    int unsigned pos;

    logic [31:0] addr_tab [11] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14,
                                   32'h18, 32'h1C, 32'h02, 32'h20, 32'h104};

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_err(input logic [31:0] a, input logic wr);
        return (a[1:0] != 2'd0) || (a > 32'h10) || (wr && (a == 32'h10));
    endfunction

    function automatic int unsigned m_pos();
        return cyc - m_start;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        case (a)
            32'h00:  return {29'd0, m_ie, m_pol, m_en};
            32'h04:  return m_per;
            32'h08:  return m_duty;
            32'h0C:  return {30'd0, m_en, m_wrap};
            32'h10:  return m_pos();
            default: return 32'd0;
        endcase
    endfunction

    always @(negedge pclk) begin
        #2;
        if (!presetn) begin
            m_en = 0; m_pol = 0; m_ie = 0; m_wrap = 0; m_pwm = 0;
            m_per = 0; m_duty = 0; m_per_a = 0; m_duty_a = 0;
            cyc++;
            m_start = cyc;
            chk1("rst_pready", pready, 1'b0);
            chk1("rst_pslverr", pslverr, 1'b0);
            chk32("rst_prdata", prdata, 32'd0);
            chk1("rst_pwm_out", pwm_out, 1'b0);
            chk1("rst_irq", irq, 1'b0);
        end else begin
            rdy_t = exp_ready;
            err_t = m_err(paddr, pwrite);
            chk1("pready", pready, rdy_t);
            chk1("pslverr", pslverr, rdy_t && err_t);
            chk32("prdata", prdata, (rdy_t && !pwrite && !err_t) ? m_read(paddr) : 32'd0);
            chk1("pwm_out", pwm_out, m_pwm);
            chk1("irq", irq, m_wrap && m_ie);
            pos   = m_pos();
            hit   = m_en && (pos == m_per_a);
            m_pwm = m_en ? ((pos < m_duty_a) ^ m_pol) : m_pol;
            if (!m_en || hit) begin
                m_start  = cyc + 1;
                m_per_a  = m_per;
                m_duty_a = m_duty;
            end
            wr_ok = rdy_t && pwrite && !err_t;
            if (wr_ok && paddr == 32'h00) {m_ie, m_pol, m_en} = pwdata[2:0];
            if (wr_ok && paddr == 32'h04) m_per = 32'(pwdata[CNT_W-1:0]);
            if (wr_ok && paddr == 32'h08) m_duty = 32'(pwdata[CNT_W-1:0]);
            if (hit) m_wrap = 1'b1;
            else if (wr_ok && paddr == 32'h0C && pwdata[0]) m_wrap = 1'b0;
            cyc++;
        end
    end

    task automatic apb(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(negedge pclk);
        penable = 1'b1;
        repeat (WS) @(negedge pclk);
        exp_ready = 1'b1;
        #3;
        rd = prdata;
        er = pslverr;
        @(negedge pclk);
        exp_ready = 1'b0; psel = 1'b0; penable = 1'b0;
    endtask

    task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd;
        logic er;
        apb(1'b1, a, d, rd, er);
    endtask

    task automatic apb_abort(input logic [31:0] a, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
    endtask

    task automatic count_high(input int n, output int hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            #3;
            if (pwm_out) hi++;
            @(negedge pclk);
        end
    endtask

    task automatic wait_pos(input int unsigned p);
        int guard;
        guard = 0;
        while (m_pos() != p && guard < 500) begin
            @(negedge pclk);
            guard++;
        end
        if (guard >= 500) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_pos: position %0d not reached", p);
        end
    endtask

    task automatic check_irq(input string name, input logic exp);
        #3;
        chk1(name, irq, exp);
        @(negedge pclk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          hi;
        logic        w;
        logic [31:0] a, d;

        repeat (3) @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);

        for (int i = 0; i < 5; i++) begin
            apb(1'b0, addr_tab[i], 32'd0, rd, er);
            chk32("reset_read", rd, 32'd0);
            chk1("reset_read_err", er, 1'b0);
        end

        apb_wr(32'h04, 32'd9);
        apb_wr(32'h08, 32'd3);
        apb_wr(32'h00, 32'd1);
        apb(1'b0, 32'h0C, 32'd0, rd, er);
        chk32("status_run_nowrap", rd, 32'h2);
        apb(1'b0, 32'h04, 32'd0, rd, er);
        chk32("period_readback", rd, 32'd9);
        apb(1'b0, 32'h08, 32'd0, rd, er);
        chk32("duty_readback", rd, 32'd3);
        wait_pos(1);
        count_high(10, hi);
        chk32("duty3_high", hi, 32'd3);
        apb(1'b0, 32'h0C, 32'd0, rd, er);
        chk32("status_wrap", rd, 32'h3);

        wait_pos(0);
        apb_wr(32'h08, 32'd7);
        count_high(8, hi);
        chk32("duty_shadow_hold", hi, 32'd1);
        wait_pos(1);
        count_high(10, hi);
        chk32("duty7_high", hi, 32'd7);

        apb_wr(32'h08, 32'd0);
        repeat (12) @(negedge pclk);
        count_high(20, hi);
        chk32("duty0_low", hi, 32'd0);
        apb_wr(32'h08, 32'd12);
        repeat (12) @(negedge pclk);
        count_high(20, hi);
        chk32("duty12_high", hi, 32'd20);
        apb_wr(32'h00, 32'd3);
        repeat (2) @(negedge pclk);
        count_high(20, hi);
        chk32("pol_duty12", hi, 32'd0);
        apb_wr(32'h08, 32'd0);
        repeat (12) @(negedge pclk);
        count_high(20, hi);
        chk32("pol_duty0", hi, 32'd20);
        apb_wr(32'h00, 32'd2);
        repeat (2) @(negedge pclk);
        count_high(10, hi);
        chk32("disabled_pol", hi, 32'd10);

        apb_wr(32'h00, 32'd5);
        apb(1'b0, 32'h14, 32'd0, rd, er);
        chk1("err_unmapped", er, 1'b1);
        chk32("err_unmapped_data", rd, 32'd0);
        apb(1'b1, 32'h10, 32'h5A, rd, er);
        chk1("err_cnt_write", er, 1'b1);
        apb(1'b0, 32'h02, 32'd0, rd, er);
        chk1("err_unaligned", er, 1'b1);
        chk32("err_unaligned_data", rd, 32'd0);
        apb(1'b1, 32'h01, 32'd0, rd, er);
        chk1("err_unaligned_wr", er, 1'b1);
        apb(1'b1, 32'h20, 32'd0, rd, er);
        chk1("err_high_addr", er, 1'b1);
        apb(1'b0, 32'h00, 32'd0, rd, er);
        chk32("ctrl_after_errors", rd, 32'd5);
        apb_abort(32'h00, 32'd0);
        apb(1'b0, 32'h00, 32'd0, rd, er);
        chk32("ctrl_after_abort", rd, 32'd5);

        apb_wr(32'h04, 32'd9);
        apb_wr(32'h08, 32'd3);
        apb(1'b0, 32'h04, 32'd0, rd, er);
        chk32("b2b_period", rd, 32'd9);
        apb(1'b0, 32'h08, 32'd0, rd, er);
        chk32("b2b_duty", rd, 32'd3);

        wait_pos(2);
        apb_wr(32'h0C, 32'd1);
        check_irq("irq_cleared", 1'b0);
        wait_pos(0);
        check_irq("irq_on_wrap", 1'b1);
        wait_pos(7);
        apb_wr(32'h0C, 32'd1);
        check_irq("irq_w1c_on_wrap", 1'b1);
        apb(1'b0, 32'h0C, 32'd0, rd, er);
        chk32("wrap_beats_w1c", rd, 32'h3);
        wait_pos(2);
        apb_wr(32'h0C, 32'd1);
        check_irq("irq_later_clear", 1'b0);

        for (int n = 0; n < 250; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge pclk);
            a = addr_tab[$urandom_range(0, 10)];
            w = 1'($urandom_range(0, 1));
            d = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 12));
            if ($urandom_range(0, 15) == 0) apb_abort(a, d);
            else apb(w, a, d, rd, er);
        end

        apb_wr(32'h00, 32'd2);
        repeat (3) @(negedge pclk);
        #3;
        chk1("pol_idle_high", pwm_out, 1'b1);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0C;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        exp_ready = 1'b1;
        #3;
        presetn = 1'b0;
        #1;
        chk1("async_rst_pready", pready, 1'b0);
        chk1("async_rst_pwm", pwm_out, 1'b0);
        chk32("async_rst_prdata", prdata, 32'd0);
        psel = 1'b0; penable = 1'b0; exp_ready = 1'b0;
        repeat (2) @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        apb(1'b0, 32'h00, 32'd0, rd, er);
        chk32("ctrl_after_reset", rd, 32'd0);
        apb(1'b0, 32'h08, 32'd0, rd, er);
        chk32("duty_after_reset", rd, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
